shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter; successor to the single-row combinational shift rows. Each stage shifts by 2^k when count bit k is set, with a register after every stage. A valid/ready handshake gives full throughput with backpressure. Adds rotate-right, a tag passthrough and a synchronous flush. Serves as the shift unit of the execute stage and can be reused for any WIDTH that is a power of two.

Parameters:
WIDTH, 16, data width; power of two, 8..64
LOG2W, $clog2(WIDTH), stage count; derived, not overridden
TAG_W, 4, width of the opaque tag carried alongside data

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous; drops all in-flight entries
in_valid  in  1  input entry valid
in_ready  out  1  shifter can accept this cycle
in_data  in  WIDTH  operand
in_cnt  in  LOG2W  shift amount, 0..WIDTH-1
in_op  in  3  operation code (see Behaviour)
in_tag  in  TAG_W  passthrough tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts this cycle
out_data  out  WIDTH  result
out_tag  out  TAG_W  tag of the result
out_err  out  1  result came from a reserved op

Behaviour:
- Op encoding: 000 ROL, 001 SLL (zero fill), 010 SRA (sign fill from original MSB), 011 SRL (zero fill), 100 ROR. Codes 101..111 are reserved: data passes unshifted and err=1.
- Stage k (0..LOG2W-1): if cnt[k]=1, shift by 2^k per op, otherwise pass through. Each stage carries {valid, data, cnt, op, tag, err} into its register.
- Stage ready: ready_k = !valid_k || ready_{k+1}. ready_LOG2W = out_ready. in_ready = ready_0. Stage k loads from k-1 when ready_k. Bubbles collapse.
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Latency: exactly LOG2W cycles from accept to out_valid when out_ready stays high. Throughput is 1 result per cycle.
- out_* are driven directly from the last stage register; no combinational path from in_* to out_*.
- Backpressure: while out_ready=0, out_valid, out_data, out_tag and out_err hold stable. Upstream stages fill, and in_ready drops only when every stage is valid.
- Simultaneous accept and deliver on a full pipe: legal, no loss, no duplicate.
- cnt=0: data passes unchanged for every op, including SRA.
- SRA by WIDTH-1 gives all bits equal to the original MSB.
- Reset (rst=1 at a clock edge): all stage valids 0, all data/tag/err registers 0. Hence out_valid=0, out_data=0, out_tag=0, out_err=0, and in_ready=1 from the next cycle. Any in-flight entries are discarded. Inputs are ignored during the reset cycle.
- flush=1: all valid bits cleared at the edge; data registers keep their contents (don't-care). An input presented in the same cycle is dropped. flush together with rst behaves as rst.
- No X propagation: data registers load only when their valid bit is loaded.

Decomposition:
- shifter_pkg:
  - op localparams OP_ROL, OP_SLL, OP_SRA, OP_SRL, OP_ROR
  - function op_is_reserved
  - MAX_WIDTH constant
- Sub-module shift_stage (params WIDTH, AMT): combinational, one conditional shift by AMT for all five ops. shifter_pipe instantiates LOG2W of them with AMT=2^k inside a generate loop and owns all registers and handshake logic.

Test Plan (WIDTH=16):
- Op coverage: after reset, in_data=16'h8421, cnt=4, each op with out_ready=1:
  - ROL -> 16'h4218
  - SLL -> 16'h4210
  - SRA -> 16'hF842
  - SRL -> 16'h0842
  - ROR -> 16'h1842
  - each appears exactly 4 cycles after accept.
- Streaming: 16 back-to-back inputs with tags 0..15 and out_ready=1 -> 16 consecutive out_valid cycles, tags in order, no gaps, in_ready never drops.
- Backpressure: out_ready=0 for 10 cycles while inputs keep streaming -> in_ready falls after 4 accepts and out_data holds stable. Releasing out_ready delivers all 4 in order with no loss.
- Flush mid-stream: flush asserted with 3 entries in flight -> out_valid=0 the next cycle, none of the 3 appear later, and a new input accepted afterwards arrives after 4 cycles.
- Edges:
  - SRA 16'h8000 cnt=15 -> 16'hFFFF
  - SRL 16'h8000 cnt=15 -> 16'h0001
  - ROL 16'h8000 cnt=1 -> 16'h0001
  - any op with cnt=0 -> unchanged
  - op 3'b110 -> data unchanged, out_err=1
- Reset mid-operation: rst with a full pipe and out_ready=0 -> the next cycle shows out_valid=0, out_data=0, in_ready=1. No stale result emerges later.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op codes and helpers for the pipelined barrel shifter.
// Reserved op codes pass data through unshifted and raise an error flag.
package shifter_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter row: conditional shift by AMT for all five ops.
// Purely combinational, zero latency, no handshake of its own.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // SRA fills from the current MSB; earlier SRA rows preserve it, so this is the original sign.
  always_comb begin
    dout = din;
    if (en) begin
      case (op)
        OP_ROL:  dout = {din[WIDTH-AMT-1:0], din[WIDTH-1:WIDTH-AMT]};
        OP_SLL:  dout = {din[WIDTH-AMT-1:0], {AMT{1'b0}}};
        OP_SRA:  dout = {{AMT{din[WIDTH-1]}}, din[WIDTH-1:AMT]};
        OP_SRL:  dout = {{AMT{1'b0}}, din[WIDTH-1:AMT]};
        OP_ROR:  dout = {din[AMT-1:0], din[WIDTH-1:AMT]};
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter, LOG2W cycles accept-to-result, one result per cycle.
// Per-stage valid/ready: bubbles collapse, in_ready drops only when every stage holds an entry.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int LOG2W = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_cnt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [LOG2W-1:0] vld_q;
  logic [LOG2W-1:0] err_q;
  logic [WIDTH-1:0] dat_q [LOG2W];
  logic [TAG_W-1:0] tag_q [LOG2W];
  // The last stage needs no count/op: its shift is already applied.
  logic [LOG2W-1:0] cnt_q [LOG2W-1];
  logic [2:0]       op_q  [LOG2W-1];

  logic [LOG2W-1:0] rdy;
  logic [LOG2W-1:0] src_vld;
  logic [LOG2W-1:0] src_err;
  logic [WIDTH-1:0] src_dat [LOG2W];
  logic [TAG_W-1:0] src_tag [LOG2W];
  logic [LOG2W-1:0] src_cnt [LOG2W];
  logic [2:0]       src_op  [LOG2W];
  logic [WIDTH-1:0] sh_dat  [LOG2W];

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_vld[0] = in_valid;
      assign src_err[0] = op_is_reserved(in_op);
      assign src_dat[0] = in_data;
      assign src_tag[0] = in_tag;
      assign src_cnt[0] = in_cnt;
      assign src_op[0]  = in_op;
    end else begin : g_link
      assign src_vld[k] = vld_q[k-1];
      assign src_err[k] = err_q[k-1];
      assign src_dat[k] = dat_q[k-1];
      assign src_tag[k] = tag_q[k-1];
      assign src_cnt[k] = cnt_q[k-1];
      assign src_op[k]  = op_q[k-1];
    end

    // Unrolled form of ready_k = !valid_k || ready_{k+1}.
    assign rdy[k] = out_ready | ~(&vld_q[LOG2W-1:k]);

    shift_stage #(
      .WIDTH(WIDTH),
      .AMT  (1 << k)
    ) u_shift (
      .en  (src_cnt[k][k]),
      .op  (src_op[k]),
      .din (src_dat[k]),
      .dout(sh_dat[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < LOG2W; k++) begin
        dat_q[k] <= '0;
        tag_q[k] <= '0;
      end
      for (int k = 0; k < LOG2W - 1; k++) begin
        cnt_q[k] <= '0;
        op_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LOG2W; k++) begin
        if (flush) begin
          vld_q[k] <= 1'b0;
        end else if (rdy[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            dat_q[k] <= sh_dat[k];
            tag_q[k] <= src_tag[k];
            err_q[k] <= src_err[k];
          end
        end
      end
      for (int k = 0; k < LOG2W - 1; k++) begin
        if (!flush && rdy[k] && src_vld[k]) begin
          cnt_q[k] <= src_cnt[k];
          op_q[k]  <= src_op[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[LOG2W-1];
  assign out_data  = dat_q[LOG2W-1];
  assign out_tag   = tag_q[LOG2W-1];
  assign out_err   = err_q[LOG2W-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Randomized bench for shifter_pipe (WIDTH=16) against a bit-level reference model.
module tb_shifter_pipe;

  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_cnt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;

  shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          e;
    int            cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_exp[$];
  rec_t got_obs[$];
  int   cyc = 0;
  int   spurious = 0;
  int   total = 0;
  int   bad = 0;

  // Reference: each result bit taken directly from its source bit in the operand.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [3:0] c, input logic [2:0] op);
    logic [W-1:0] r;
    int n;
    n = int'(c);
    r = d;
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0: r[(i + n) % W] = d[i];
        3'd1: r[i] = (i >= n) ? d[(i - n + W) % W] : 1'b0;
        3'd2: r[i] = (i + n < W) ? d[(i + n) % W] : d[W-1];
        3'd3: r[i] = (i + n < W) ? d[(i + n) % W] : 1'b0;
        3'd4: r[i] = d[(i + n) % W];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Advance one clock, logging accepts and deliveries seen just before the edge.
  task automatic tick();
    rec_t e;
    rec_t o;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      o.d = out_data; o.t = out_tag; o.e = out_err; o.cyc = cyc;
      if (exp_q.size() > 0) begin
        got_exp.push_back(exp_q.pop_front());
        got_obs.push_back(o);
      end else begin
        spurious++;
      end
    end
    if (!rst && !flush && in_valid && in_ready) begin
      e.d = model(in_data, in_cnt, in_op); e.t = in_tag; e.e = (in_op > 3'd4); e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (rst || flush) exp_q.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    timed_out = (exp_q.size() > 0);
  endtask

  task automatic clear_log();
    got_exp.delete();
    got_obs.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'hFFFF;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_ops();
    logic [W-1:0] want [5] = '{16'h4218, 16'h4210, 16'hF842, 16'h0842, 16'h1842};
    bit to;
    out_ready = 1'b1;
    for (int op = 0; op < 5; op++) begin
      clear_log();
      in_valid = 1'b1; in_data = 16'h8421; in_cnt = 4'd4; in_op = op[2:0]; in_tag = op[3:0];
      tick();
      in_valid = 1'b0;
      drain(20, to);
      total++;
      if (to || got_obs.size() != 1) begin
        bad++; $display("FAIL op%0d_count got=%0d want=1", op, got_obs.size());
      end else begin
        if (got_obs[0].d !== want[op]) begin bad++; $display("FAIL op%0d_data got=%h want=%h", op, got_obs[0].d, want[op]); end
        total++;
        if (got_obs[0].cyc - got_exp[0].cyc != 4) begin
          bad++; $display("FAIL op%0d_latency got=%0d want=4", op, got_obs[0].cyc - got_exp[0].cyc);
        end
        total++;
        if (got_obs[0].t !== op[3:0] || got_obs[0].e !== 1'b0) begin
          bad++; $display("FAIL op%0d_tag_err got=%h/%b want=%h/0", op, got_obs[0].t, got_obs[0].e, op[3:0]);
        end
      end
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ed [9] = '{16'h8000, 16'h8000, 16'h8000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hBEEF};
    logic [3:0]   ec [9] = '{4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
    logic [2:0]   eo [9] = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [W-1:0] ew [9] = '{16'hFFFF, 16'h0001, 16'h0001, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hBEEF};
    logic         ee [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit to;
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = ed[i]; in_cnt = ec[i]; in_op = eo[i]; in_tag = i[3:0];
      tick();
    end
    in_valid = 1'b0;
    drain(20, to);
    total++;
    if (to || got_obs.size() != 9) begin
      bad++; $display("FAIL edge_count got=%0d want=9", got_obs.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (got_obs[i].d !== ew[i] || got_obs[i].e !== ee[i]) begin
          bad++; $display("FAIL edge%0d got=%h/err%b want=%h/err%b", i, got_obs[i].d, got_obs[i].e, ew[i], ee[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int drops;
    clear_log();
    drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_cnt = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 4)); in_tag = i[3:0];
      if (in_ready !== 1'b1) drops++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (drops != 0) begin bad++; $display("FAIL stream_in_ready_drops got=%0d want=0", drops); end
    drain(20, to);
    total++;
    if (to || got_obs.size() != 16) begin
      bad++; $display("FAIL stream_count got=%0d want=16", got_obs.size());
    end else begin
      total++;
      if (got_obs[0].cyc - got_exp[0].cyc != 4) begin
        bad++; $display("FAIL stream_latency got=%0d want=4", got_obs[0].cyc - got_exp[0].cyc);
      end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (got_obs[i].t !== i[3:0] || got_obs[i].d !== got_exp[i].d || got_obs[i].cyc != got_obs[0].cyc + i) begin
          bad++; $display("FAIL stream%0d got=tag%h data%h cyc%0d want=tag%h data%h cyc%0d", i,
                          got_obs[i].t, got_obs[i].d, got_obs[i].cyc, i[3:0], got_exp[i].d, got_obs[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit have_snap;
    bit changed;
    logic [W-1:0] snap;
    clear_log();
    have_snap = 1'b0; changed = 1'b0; snap = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_cnt = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 4)); in_tag = c[3:0];
      tick();
      if (out_valid === 1'b1 && !have_snap) begin
        have_snap = 1'b1; snap = out_data;
      end else if (have_snap && out_data !== snap) begin
        changed = 1'b1;
      end
    end
    total++; if (exp_q.size() != 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", exp_q.size()); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    total++; if (changed) begin bad++; $display("FAIL bp_hold got=changed want=stable snap=%h now=%h", snap, out_data); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20, to);
    total++;
    if (to || got_obs.size() != 4) begin
      bad++; $display("FAIL bp_drain_count got=%0d want=4", got_obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_obs[i].t !== i[3:0] || got_obs[i].d !== got_exp[i].d) begin
          bad++; $display("FAIL bp_drain%0d got=tag%h data%h want=tag%h data%h", i, got_obs[i].t, got_obs[i].d, i[3:0], got_exp[i].d);
        end
      end
    end
  endtask

  task automatic test_flush();
    bit to;
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_cnt = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 4)); in_tag = i[3:0];
      tick();
    end
    flush = 1'b1; in_tag = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    repeat (10) tick();
    total++;
    if (got_obs.size() != 0 || spurious != 0) begin
      bad++; $display("FAIL flush_leak got=%0d/%0d want=0/0", got_obs.size(), spurious);
    end
    in_valid = 1'b1; in_data = 16'h1234; in_cnt = 4'd8; in_op = 3'd4; in_tag = 4'h9;
    tick();
    in_valid = 1'b0;
    drain(20, to);
    total++;
    if (to || got_obs.size() != 1) begin
      bad++; $display("FAIL flush_after_count got=%0d want=1", got_obs.size());
    end else if (got_obs[0].d !== 16'h3412 || got_obs[0].t !== 4'h9 || got_obs[0].cyc - got_exp[0].cyc != 4) begin
      bad++; $display("FAIL flush_after got=%h/tag%h/lat%0d want=3412/tag9/lat4", got_obs[0].d, got_obs[0].t,
                      got_obs[0].cyc - got_exp[0].cyc);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = W'($urandom) | 16'h0101; in_cnt = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 7)); in_tag = i[3:0];
      tick();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b want=0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state got=v%b d%h r%b want=v0 d0000 r1", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (got_obs.size() != 0 || spurious != 0) begin
      bad++; $display("FAIL rstmid_stale got=%0d/%0d want=0/0", got_obs.size(), spurious);
    end
  endtask

  task automatic test_random();
    bit to;
    clear_log();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      in_data = W'($urandom); in_cnt = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 7)); in_tag = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(50, to);
    total++; if (to) begin bad++; $display("FAIL rand_drain got=%0d left want=0", exp_q.size()); end
    total++; if (got_obs.size() < 100) begin bad++; $display("FAIL rand_volume got=%0d want>=100", got_obs.size()); end
    for (int i = 0; i < got_obs.size(); i++) begin
      total++;
      if (got_obs[i].d !== got_exp[i].d || got_obs[i].t !== got_exp[i].t || got_obs[i].e !== got_exp[i].e) begin
        bad++; $display("FAIL rand%0d got=%h/%h/%b want=%h/%h/%b", i, got_obs[i].d, got_obs[i].t, got_obs[i].e,
                        got_exp[i].d, got_exp[i].t, got_exp[i].e);
      end
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL spurious got=%0d want=0", spurious); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
    test_reset();
    test_ops();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
